// File: rtl/conv_window_gen_pkg.sv
// Shared 3x3 convolution definitions: window geometry and point packing order.
// The convolution array imports this same package so both sides agree on layout.
package conv_window_gen_pkg;

  localparam int FILTER_DIM = 3;
  localparam int NUM_POINTS = FILTER_DIM * FILTER_DIM;

  // Rows of a window, oldest line first.
  typedef enum int {
    WIN_ROW_OLDEST = 0,
    WIN_ROW_MID    = 1,
    WIN_ROW_NEWEST = 2
  } win_row_e;

  // Bits occupied by one channel's window.
  function automatic int unit_bits(input int data_width);
    return NUM_POINTS * data_width;
  endfunction

  // Point index inside a window: row-major, row 0 oldest, col 0 leftmost.
  function automatic int point_idx(input int row, input int col);
    return row * FILTER_DIM + col;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Single-port row memory with asynchronous read-before-write behaviour,
// one entry per pixel column holding all channels of that pixel.
module conv_line_buffer #(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The read returns the entry as it was before this cycle's write lands.
  assign rd_data = mem[addr];

  // NOTE: storage has no reset so it maps onto RAM; stale contents are masked
  // downstream by the window-valid gating.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streams packed multi-channel pixels in raster order and emits a 3x3 window
// per channel for every fully-populated position (valid padding only).
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int FILTER_SIZE  = 3,
  parameter int IMG_WIDTH    = 32,
  parameter int IMG_HEIGHT   = 32
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       i_valid,
  input  logic                                       i_sof,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]         i_pixels_packed,
  output logic [NUM_CHANNELS*NUM_POINTS*DATA_WIDTH-1:0] o_windows_packed,
  output logic                                       o_valid,
  output logic                                       o_eof
);

  localparam int UNIT_BITS = unit_bits(DATA_WIDTH);
  localparam int BEAT_BITS = NUM_CHANNELS * DATA_WIDTH;
  localparam int COL_W     = $clog2(IMG_WIDTH);
  localparam int ROW_W     = $clog2(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(FILTER_DIM - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(FILTER_DIM - 1);

  generate
    if (FILTER_SIZE != FILTER_DIM) begin : g_bad_filter
      $error("conv_window_gen supports FILTER_SIZE=3 only");
    end
    if (IMG_WIDTH < FILTER_DIM || IMG_HEIGHT < FILTER_DIM) begin : g_bad_image
      $error("conv_window_gen needs an image of at least 3x3");
    end
  endgenerate

  logic [COL_W-1:0] col, cur_col, nxt_col;
  logic [ROW_W-1:0] row, cur_row, nxt_row;
  logic [BEAT_BITS-1:0] lb0_rd, lb1_rd;
  logic [DATA_WIDTH-1:0] win [NUM_CHANNELS][NUM_POINTS];

  // Position of the beat being accepted; start-of-frame overrides the counters.
  // NOTE: every output of this block gets a value on every path, so no latch.
  always_comb begin
    cur_col = col;
    cur_row = row;
    if (i_valid && i_sof) begin
      cur_col = '0;
      cur_row = '0;
    end
    nxt_col = cur_col + COL_W'(1);
    nxt_row = cur_row;
    if (cur_col == COL_LAST) begin
      nxt_col = '0;
      nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
    end
  end

  // NOTE: asynchronous active-low reset, and sequential state uses <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      o_valid <= 1'b0;
      o_eof   <= 1'b0;
    end else begin
      o_valid <= i_valid && (cur_row >= ROW_FIRST_WIN) && (cur_col >= COL_FIRST_WIN);
      o_eof   <= i_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      if (i_valid) begin
        col <= nxt_col;
        row <= nxt_row;
      end
    end
  end

  // LB0 holds the previous row; LB1 receives what LB0 held (two rows back).
  conv_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (BEAT_BITS),
    .ADDR_W(COL_W)
  ) u_lb0 (
    .clk    (clk),
    .we     (i_valid),
    .addr   (cur_col),
    .wr_data(i_pixels_packed),
    .rd_data(lb0_rd)
  );

  conv_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (BEAT_BITS),
    .ADDR_W(COL_W)
  ) u_lb1 (
    .clk    (clk),
    .we     (i_valid),
    .addr   (cur_col),
    .wr_data(lb0_rd),
    .rd_data(lb1_rd)
  );

  // Shift the window one column left and load the new rightmost column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        for (int p = 0; p < NUM_POINTS; p++) begin
          win[k][p] <= '0;
        end
      end
    end else if (i_valid) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        for (int r = 0; r < FILTER_DIM; r++) begin
          win[k][point_idx(r, 0)] <= win[k][point_idx(r, 1)];
          win[k][point_idx(r, 1)] <= win[k][point_idx(r, 2)];
        end
        win[k][point_idx(WIN_ROW_OLDEST, 2)] <= lb1_rd[k*DATA_WIDTH +: DATA_WIDTH];
        win[k][point_idx(WIN_ROW_MID, 2)]    <= lb0_rd[k*DATA_WIDTH +: DATA_WIDTH];
        win[k][point_idx(WIN_ROW_NEWEST, 2)] <= i_pixels_packed[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  generate
    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
      for (genvar p = 0; p < NUM_POINTS; p++) begin : g_pt
        assign o_windows_packed[k*UNIT_BITS + p*DATA_WIDTH +: DATA_WIDTH] = win[k][p];
      end
    end
  endgenerate

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 5x4 two-channel image.
module tb_conv_window_gen;

  localparam int NC = 2;
  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int BB = NC * DW;
  localparam int WB = NC * 9 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_sof = 1'b0;
  logic [BB-1:0] i_pixels_packed = '0;
  logic [WB-1:0] o_windows_packed;
  logic          o_valid;
  logic          o_eof;

  always #5 clk = ~clk;

  conv_window_gen #(
    .NUM_CHANNELS(NC),
    .DATA_WIDTH  (DW),
    .FILTER_SIZE (3),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_valid         (i_valid),
    .i_sof           (i_sof),
    .i_pixels_packed (i_pixels_packed),
    .o_windows_packed(o_windows_packed),
    .o_valid         (o_valid),
    .o_eof           (o_eof)
  );

  typedef struct {
    logic [WB-1:0] win;
    logic          eof;
    int            sum;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   n_windows = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Test image: ch0 = off + row*16 + col, ch1 = 0x80 + the same.
  function automatic logic [DW-1:0] pix(input int off, input int k, input int r, input int c);
    return DW'(k * 128 + off + r * 16 + c);
  endfunction

  function automatic logic [WB-1:0] exp_window(input int off, input int r, input int c);
    logic [WB-1:0] w;
    w = '0;
    for (int k = 0; k < NC; k++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[k*72 + (i*3+j)*DW +: DW] = pix(off, k, r - 2 + i, c - 2 + j);
    return w;
  endfunction

  // Drive one beat; positions with a full window queue their expected output.
  task automatic drive_beat(input int off, input int r, input int c, input logic sof);
    exp_t e;
    i_valid = 1'b1;
    i_sof   = sof;
    for (int k = 0; k < NC; k++) i_pixels_packed[k*DW +: DW] = pix(off, k, r, c);
    if (r >= 2 && c >= 2) begin
      e.win = exp_window(off, r, c);
      e.eof = (r == H - 1) && (c == W - 1);
      // All-ones 3x3 kernel summed across both channels, in closed form.
      e.sum = 18 * (off + (r - 1) * 16 + (c - 1)) + 9 * 128;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic gap_cycle(input logic have_last, input logic [WB-1:0] last);
    @(posedge clk);
    #1;
    check("gap_valid_low", 256'(o_valid), 256'(0));
    if (have_last) check("gap_window_hold", 256'(o_windows_packed), 256'(last));
  endtask

  task automatic send_frame(input int off, input int n_beats, input bit gaps, input bit use_sof);
    for (int idx = 0; idx < n_beats; idx++) begin
      int r, c;
      r = idx / W;
      c = idx % W;
      drive_beat(off, r, c, (idx == 0) && use_sof);
      if (gaps && $urandom_range(0, 1) == 1)
        gap_cycle(r >= 2 && c >= 2, exp_window(off, r, c));
    end
  endtask

  task automatic section_done(input string name, input int base, input int want);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_window_count"}, 256'(n_windows - base), 256'(want));
    check({name, "_queue_empty"}, 256'(sb_q.size()), 256'(0));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a window.
  initial begin
    forever begin
      @(negedge clk);
      if (o_valid) begin
        n_windows++;
        if (sb_q.size() == 0) begin
          check("unexpected_window", 256'(o_valid), 256'(0));
        end else begin
          exp_t e;
          int   s;
          e = sb_q.pop_front();
          s = 0;
          for (int k = 0; k < NC; k++)
            for (int p = 0; p < 9; p++)
              s += int'(o_windows_packed[k*72 + p*DW +: DW]);
          check("window", 256'(o_windows_packed), 256'(e.win));
          check("eof", 256'(o_eof), 256'(e.eof));
          check("kernel_sum", 256'(s), 256'(e.sum));
        end
      end else if (o_eof) begin
        check("eof_without_valid", 256'(o_eof), 256'(0));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 256'(o_valid), 256'(0));
    check("reset_eof", 256'(o_eof), 256'(0));
    check("reset_windows", 256'(o_windows_packed), 256'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Continuous frame.
    base = n_windows;
    send_frame(8'h00, W * H, 1'b0, 1'b1);
    section_done("continuous", base, 6);

    // Random idle cycles between beats.
    base = n_windows;
    send_frame(8'h00, W * H, 1'b1, 1'b1);
    section_done("gaps", base, 6);

    // Back-to-back frames; the second must not see first-frame data.
    base = n_windows;
    send_frame(8'h00, W * H, 1'b0, 1'b1);
    send_frame(8'h40, W * H, 1'b0, 1'b1);
    section_done("back_to_back", base, 12);

    // Start-of-frame on what would be beat (1,3) restarts the counters.
    base = n_windows;
    send_frame(8'h00, W + 3, 1'b0, 1'b1);
    send_frame(8'h40, W * H, 1'b0, 1'b1);
    section_done("sof_restart", base, 6);

    // Reset while beat (2,3) is on the bus, after the (2,2) window is out.
    base = n_windows;
    send_frame(8'h10, 2 * W + 3, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    i_valid = 1'b1;
    for (int k = 0; k < NC; k++) i_pixels_packed[k*DW +: DW] = pix(8'h10, k, 2, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 256'(o_valid), 256'(0));
    check("async_reset_eof", 256'(o_eof), 256'(0));
    check("async_reset_windows", 256'(o_windows_packed), 256'(0));
    i_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // No start-of-frame marker: the first beat after reset is (0,0) by itself.
    send_frame(8'h20, W * H, 1'b0, 1'b0);
    section_done("reset_restart", base, 7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 8: number of channels packed per pixel beat.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: pixel bit width.
REQ-003 SHALL have parameter FILTER_SIZE, default 3: window size; only 3 supported, any other value is an elaboration error.
REQ-004 SHALL have parameter IMG_WIDTH, default 32: pixels per row (min 3).
REQ-005 SHALL have parameter IMG_HEIGHT, default 32: rows per frame (min 3).
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port i_valid, input, 1 bit: pixel beat valid; no backpressure.
REQ-009 SHALL have port i_sof, input, 1 bit: qualified by i_valid; marks the beat as pixel (0,0).
REQ-010 SHALL have port i_pixels_packed, input, NUM_CHANNELS*DATA_WIDTH bits: channel k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port o_windows_packed, output, NUM_CHANNELS*9*DATA_WIDTH bits: channel k window at [k*72 +: 72] (DATA_WIDTH=8); inside it, point p = row*3+col at [p*DATA_WIDTH +: DATA_WIDTH], row 0 = oldest line, col 0 = leftmost column.
REQ-012 SHALL have port o_valid, output, 1 bit: window valid; drives the convolution array's i_valid directly.
REQ-013 SHALL have port o_eof, output, 1 bit: asserted with o_valid on the frame's last window.

Function
REQ-014 SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), advancing only on i_valid.
REQ-015 SHALL wrap col to 0 and increment row at col = IMG_WIDTH-1; at (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0.
REQ-016 SHALL force the beat to position (0,0) when i_valid&&i_sof, whatever the counter state; the next beat is (0,1).
REQ-017 SHALL keep two line buffers per channel, depth IMG_WIDTH: LB0 holds row-1 and LB1 holds row-2.
REQ-018 On each valid beat at column c, SHALL form new window column {LB1[c], LB0[c], pixel}, shift the 3x3 window registers one column left, then write LB1[c]<=LB0[c] and LB0[c]<=pixel.
REQ-019 SHALL register o_valid high for the beat exactly when row>=2 and col>=2; latency is 1 cycle, so o_valid is visible the cycle after the accepted beat.
REQ-020 SHALL set o_valid low in any cycle following i_valid=0, and o_windows_packed SHALL hold its last value.
REQ-021 SHALL produce exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame; valid padding only, no zero-padded borders.
REQ-022 SHALL, through the col>=2 gating, prevent previous-row columns from appearing in any valid window across a row wrap.
REQ-023 SHALL, through the row>=2 gating, prevent stale previous-frame line-buffer data from appearing in any valid window of a new frame.
REQ-024 SHALL assert o_eof only with o_valid, for the beat at (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-025 SHALL sustain full throughput: one beat per cycle with no bubbles inserted.

Reset
REQ-026 SHALL asynchronously clear on rst_n low: col=0, row=0, o_valid=0, o_eof=0, o_windows_packed=0, window registers=0.
REQ-027 Line-buffer storage SHALL NOT be reset (RAM-inferable); its contents are don't-care, masked by REQ-019.
REQ-028 A reset mid-frame SHALL make the first post-reset beat (0,0); no window SHALL be emitted until row 2, col 2 of the restarted frame.

Structure
REQ-029 SHALL take NUM_POINTS (=9), UNIT_BITS (=NUM_POINTS*DATA_WIDTH) and the point-index/packing order from the shared conv header, which the convolution array also includes.
REQ-030 SHALL contain one sub-module, conv_line_buffer: a single-port read-before-write row memory, IMG_WIDTH deep and NUM_CHANNELS*DATA_WIDTH wide, instantiated twice (LB0, LB1).

Verification
(Common setup: NUM_CHANNELS=2, IMG_WIDTH=5, IMG_HEIGHT=4; ch0 pixel = row*16+col, ch1 pixel = 0x80+row*16+col.)
REQ-031 Continuous frame -> 6 windows; first window the cycle after beat (2,2) with ch0 p0=0x00, p4=0x11, p8=0x22 and ch1 p0=0x80; last window ch0 p8=0x34 with o_eof=1.
REQ-032 Random i_valid gaps (50%) -> same 6 windows in the same order; o_valid=0 and o_windows_packed stable during gaps.
REQ-033 Back-to-back frames with the second frame offset +0x40 -> second frame's first window ch0 p0=0x40, with no first-frame data in it.
REQ-034 i_sof asserted at beat (1,3) -> counters restart; the next window is emitted after the new (2,2), ch0 p0 equals the value sent at the new (0,0).
REQ-035 rst_n pulsed low at beat (2,3) -> o_valid drops asynchronously; after release, exactly 6 windows are produced for a full new frame.
REQ-036 Output driven into conv_3x3_parallel_top with all-ones kernels -> each sum equals the golden 3x3 sum per channel, summed across channels.
